// File: rtl/bus_decode_pkg.sv
// bus_decode_pkg: shared types and default memory map for the 6809 bus
// region decoder (SRAM, SPI flash, UART registers).
package bus_decode_pkg;

    // Decoder FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int ADDR_W      = 16;
    localparam int NUM_REGIONS = 5;
    localparam int WAIT_W      = 4;

    // Region indices (slice positions in the packed maps below)
    localparam int REG_SRAM         = 0;
    localparam int REG_FLASH        = 1;
    localparam int REG_UART_DATA    = 2;
    localparam int REG_UART_STATUS  = 3;
    localparam int REG_UART_CONTROL = 4;

    // Default memory map, inclusive bounds
    localparam logic [ADDR_W-1:0] SRAM_BASE         = 16'h1000;
    localparam logic [ADDR_W-1:0] SRAM_LIMIT        = 16'h1FFF;
    localparam logic [ADDR_W-1:0] FLASH_BASE        = 16'h3000;
    localparam logic [ADDR_W-1:0] FLASH_LIMIT       = 16'h3FFF;
    localparam logic [ADDR_W-1:0] UART_DATA_ADDR    = 16'hA000;
    localparam logic [ADDR_W-1:0] UART_STATUS_ADDR  = 16'hA001;
    localparam logic [ADDR_W-1:0] UART_CONTROL_ADDR = 16'hA002;

    localparam logic [NUM_REGIONS*ADDR_W-1:0] DEF_REGION_BASE =
        {UART_CONTROL_ADDR, UART_STATUS_ADDR, UART_DATA_ADDR, FLASH_BASE, SRAM_BASE};
    localparam logic [NUM_REGIONS*ADDR_W-1:0] DEF_REGION_LIMIT =
        {UART_CONTROL_ADDR, UART_STATUS_ADDR, UART_DATA_ADDR, FLASH_LIMIT, SRAM_LIMIT};
    localparam logic [NUM_REGIONS*WAIT_W-1:0] DEF_REGION_WAIT =
        {4'd1, 4'd1, 4'd1, 4'd3, 4'd0};

endpackage

// File: rtl/region_match.sv
// region_match: combinational priority address matcher. Reports whether any
// window contains the address and the lowest matching window index.
module region_match #(
    parameter int ADDR_W      = 16,
    parameter int NUM_REGIONS = 5,
    parameter int IDX_W       = 3,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = '0,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = '0
) (
    input  logic [ADDR_W-1:0] i_address,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_idx
);

    logic [NUM_REGIONS-1:0] w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_window
            assign w_hit[gi] = (i_address >= REGION_BASE[gi*ADDR_W +: ADDR_W]) &&
                               (i_address <= REGION_LIMIT[gi*ADDR_W +: ADDR_W]);
        end
    endgenerate

    // Priority select: scan downward so the lowest matching index is kept
    always_comb begin
        o_hit = |w_hit;
        o_idx = '0;
        for (int n = NUM_REGIONS - 1; n >= 0; n--) begin
            if (w_hit[n]) o_idx = IDX_W'(n);
        end
    end

endmodule

// File: rtl/bus_region_decoder.sv
// bus_region_decoder: registered chip-select decoder with per-region wait
// states, external-owner lock deferral and unmapped-access reporting.
// Optional macro REGION_TIMEOUT_EN: bounds the time spent waiting on a lock.
module bus_region_decoder #(
    parameter int ADDR_W      = bus_decode_pkg::ADDR_W,
    parameter int NUM_REGIONS = bus_decode_pkg::NUM_REGIONS,
    parameter int WAIT_W      = bus_decode_pkg::WAIT_W,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = bus_decode_pkg::DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = bus_decode_pkg::DEF_REGION_LIMIT,
    parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT  = bus_decode_pkg::DEF_REGION_WAIT,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [ADDR_W-1:0]      i_address,
    input  logic                   i_enable,
    input  logic [NUM_REGIONS-1:0] i_region_lock,
    output logic [NUM_REGIONS-1:0] o_ce,
    output logic                   o_ready,
    output logic                   o_miss,
    output logic                   o_err,
    output logic                   o_busy
);
    import bus_decode_pkg::*;

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    // A lock wait limit below one cycle cannot be honoured
    generate
        if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cfg
            $error("TIMEOUT_CYC must be at least 1");
        end
    endgenerate

    state_t                 r_state, w_state_next;
    logic [IDX_W-1:0]       r_idx, w_idx_next;
    logic [WAIT_W-1:0]      r_wcnt, w_wcnt_next;
    logic [NUM_REGIONS-1:0] r_ce, w_ce_next;
    logic                   r_ready, w_ready_next;
    logic                   r_miss, w_miss_next;
    logic                   w_err_next;

    logic                   w_hit;
    logic [IDX_W-1:0]       w_match_idx;
    logic [IDX_W-1:0]       w_sel_idx;
    logic [NUM_REGIONS-1:0] w_ce_onehot;
    logic [WAIT_W-1:0]      w_wait_tbl [NUM_REGIONS];
    logic                   w_sel_locked;
    logic                   w_timeout;

    region_match #(
        .ADDR_W       (ADDR_W),
        .NUM_REGIONS  (NUM_REGIONS),
        .IDX_W        (IDX_W),
        .REGION_BASE  (REGION_BASE),
        .REGION_LIMIT (REGION_LIMIT)
    ) u_match (
        .i_address (i_address),
        .o_hit     (w_hit),
        .o_idx     (w_match_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_wait
            assign w_wait_tbl[gi] = REGION_WAIT[gi*WAIT_W +: WAIT_W];
        end
    endgenerate

    // Live match only matters in IDLE; afterwards the latched index rules,
    // which is what makes later address changes irrelevant.
    assign w_sel_idx    = (r_state == ST_IDLE) ? w_match_idx : r_idx;
    assign w_ce_onehot  = {{(NUM_REGIONS-1){1'b0}}, 1'b1} << w_sel_idx;
    assign w_sel_locked = i_region_lock[w_sel_idx];

`ifdef REGION_TIMEOUT_EN
    localparam int TCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TCNT_W-1:0] r_tcnt, w_tcnt_next;
    logic              r_err;

    assign w_timeout = (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));

    // Lock-wait counter runs only while LOCKED and clears on exit
    always_comb begin
        w_tcnt_next = '0;
        if (r_state == ST_LOCKED && w_state_next == ST_LOCKED)
            w_tcnt_next = r_tcnt + 1'b1;
    end

    // Lock-wait counter and error pulse registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_tcnt <= w_tcnt_next;
            r_err  <= w_err_next;
        end
    end

    assign o_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_wcnt  <= '0;
            r_ce    <= '0;
            r_ready <= 1'b0;
            r_miss  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_wcnt  <= w_wcnt_next;
            r_ce    <= w_ce_next;
            r_ready <= w_ready_next;
            r_miss  <= w_miss_next;
        end
    end

    // Next-state decision
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    if (!w_hit)            w_state_next = ST_HOLD;
                    else if (w_sel_locked) w_state_next = ST_LOCKED;
                    else                   w_state_next = ST_ACCESS;
                end
            end
            ST_LOCKED: begin
                if (!i_enable)          w_state_next = ST_IDLE;
                else if (!w_sel_locked) w_state_next = ST_ACCESS;
                else if (w_timeout)     w_state_next = ST_HOLD;
            end
            ST_ACCESS: begin
                if (!i_enable)         w_state_next = ST_IDLE;
                else if (r_wcnt == '0) w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (!i_enable) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Next values of chip enables, pulses, latched index and wait counter
    always_comb begin
        w_ce_next    = r_ce;
        w_ready_next = 1'b0;
        w_miss_next  = 1'b0;
        w_err_next   = 1'b0;
        w_idx_next   = r_idx;
        w_wcnt_next  = r_wcnt;
        case (r_state)
            ST_IDLE: begin
                w_ce_next = '0;
                if (i_enable) begin
                    w_idx_next = w_match_idx;
                    if (!w_hit) begin
                        w_miss_next  = 1'b1;
                        w_ready_next = 1'b1;
                    end else if (!w_sel_locked) begin
                        w_ce_next   = w_ce_onehot;
                        w_wcnt_next = w_wait_tbl[w_sel_idx];
                    end
                end
            end
            ST_LOCKED: begin
                if (!i_enable) begin
                    w_ce_next = '0;
                end else if (!w_sel_locked) begin
                    w_ce_next   = w_ce_onehot;
                    w_wcnt_next = w_wait_tbl[w_sel_idx];
                end else if (w_timeout) begin
                    w_err_next   = 1'b1;
                    w_ready_next = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!i_enable)         w_ce_next    = '0;
                else if (r_wcnt == '0) w_ready_next = 1'b1;
                else                   w_wcnt_next  = r_wcnt - 1'b1;
            end
            ST_HOLD: begin
                if (!i_enable) w_ce_next = '0;
            end
            default: w_ce_next = '0;
        endcase
    end

    assign o_ce    = r_ce;
    assign o_ready = r_ready;
    assign o_miss  = r_miss;
    assign o_busy  = (r_state != ST_IDLE);

endmodule
